// File: rtl/apple_1_pia_io.sv
// Apple-1 keyboard/display PIA (6820 subset): bus register window, keyboard FIFO,
// and a single-character display slot with a valid/ready handshake.
module apple_1_pia_io #(
    parameter logic [15:0] BASE      = 16'hD010,
    parameter int unsigned KBD_DEPTH = 4,
    parameter bit          UPCASE    = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DI_pia,
    output logic        pia_hit,
    input  logic [6:0]  kbd_data,
    input  logic        kbd_valid,
    output logic        kbd_ready,
    output logic [6:0]  dsp_data,
    output logic        dsp_valid,
    input  logic        dsp_ready,
    output logic        dsp_ovr
);

    localparam int unsigned PW = (KBD_DEPTH > 1) ? $clog2(KBD_DEPTH) : 1;

    logic [6:0]  fifo_q [KBD_DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic [5:0]  cra_q, cra_d, crb_q, crb_d;
    logic [7:0]  ddra_q, ddra_d, ddrb_q, ddrb_d;
    logic [7:0]  di_q, di_d;
    logic        hit_q, hit_d;
    logic [6:0]  dsp_data_q, dsp_data_d;
    logic        dsp_valid_q, dsp_valid_d;
    logic        dsp_ovr_q, dsp_ovr_d;
    logic [6:0]  last_key_q, last_key_d;

    logic        hit, rd_en, wr_en, empty, full, push, pop;
    logic [1:0]  sel;
    logic [6:0]  key_in;
    logic [7:0]  rd_mux;

    assign hit   = (AB[15:2] == BASE[15:2]);
    assign sel   = AB[1:0];
    assign rd_en = en & ~WE;
    assign wr_en = en & WE & hit;
    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(KBD_DEPTH));

    assign kbd_ready = reset_n & ~full;
    assign push      = kbd_valid & kbd_ready;
    assign pop       = rd_en & hit & (sel == 2'd0) & cra_q[2] & ~empty;

    assign key_in = (UPCASE && kbd_data >= 7'h61 && kbd_data <= 7'h7A) ? kbd_data - 7'h20 : kbd_data;

    always_comb begin
        rd_mux = '0;
        case (sel)
            2'd0: rd_mux = cra_q[2] ? {1'b1, (empty ? last_key_q : fifo_q[head_q])} : ddra_q;
            2'd1: rd_mux = {~empty, 1'b0, cra_q};
            2'd2: rd_mux = crb_q[2] ? {dsp_valid_q, dsp_data_q} : ddrb_q;
            2'd3: rd_mux = {2'b00, crb_q};
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        cra_d       = cra_q;
        crb_d       = crb_q;
        ddra_d      = ddra_q;
        ddrb_d      = ddrb_q;
        di_d        = di_q;
        hit_d       = hit_q;
        dsp_data_d  = dsp_data_q;
        dsp_valid_d = dsp_valid_q;
        dsp_ovr_d   = dsp_ovr_q;
        last_key_d  = last_key_q;

        // Any enabled non-read cycle clears pia_hit; DI_pia keeps its last window value.
        if (rd_en) begin
            hit_d = hit;
            if (hit) di_d = rd_mux;
        end else if (en) begin
            hit_d = 1'b0;
        end

        if (wr_en) begin
            case (sel)
                2'd0: if (!cra_q[2]) ddra_d = DO;
                2'd1: cra_d = DO[5:0];
                2'd2: begin
                    if (!crb_q[2]) ddrb_d = DO;
                    else if (!dsp_valid_q) begin
                        dsp_data_d  = DO[6:0];
                        dsp_valid_d = 1'b1;
                    end else dsp_ovr_d = 1'b1;
                end
                2'd3: crb_d = DO[5:0];
                default: ;
            endcase
        end

        if (dsp_valid_q && dsp_ready) dsp_valid_d = 1'b0;

        if (pop) begin
            last_key_d = fifo_q[head_q];
            head_d     = head_q + 1'b1;
        end
        if (push) tail_d = tail_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[tail_q] <= key_in;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            cra_q       <= '0;
            crb_q       <= '0;
            ddra_q      <= '0;
            ddrb_q      <= '0;
            di_q        <= '0;
            hit_q       <= 1'b0;
            dsp_data_q  <= '0;
            dsp_valid_q <= 1'b0;
            dsp_ovr_q   <= 1'b0;
            last_key_q  <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            cra_q       <= cra_d;
            crb_q       <= crb_d;
            ddra_q      <= ddra_d;
            ddrb_q      <= ddrb_d;
            di_q        <= di_d;
            hit_q       <= hit_d;
            dsp_data_q  <= dsp_data_d;
            dsp_valid_q <= dsp_valid_d;
            dsp_ovr_q   <= dsp_ovr_d;
            last_key_q  <= last_key_d;
        end
    end

    assign DI_pia    = di_q;
    assign pia_hit   = hit_q;
    assign dsp_data  = dsp_data_q;
    assign dsp_valid = dsp_valid_q;
    assign dsp_ovr   = dsp_ovr_q;

endmodule

// File: tb/tb_apple_1_pia_io.sv
// Bench for apple_1_pia_io: queue-based reference model compared every cycle,
// directed literal checks, then randomized bus/keyboard/display traffic.
module tb_apple_1_pia_io;

    localparam logic [15:0] BASE  = 16'hD010;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] AB = '0;
    logic [7:0]  DO = '0;
    logic        WE = 1'b0;
    logic [7:0]  DI_pia;
    logic        pia_hit;
    logic [6:0]  kbd_data = '0;
    logic        kbd_valid = 1'b0;
    logic        kbd_ready;
    logic [6:0]  dsp_data;
    logic        dsp_valid;
    logic        dsp_ready = 1'b0;
    logic        dsp_ovr;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    apple_1_pia_io #(.BASE(BASE), .KBD_DEPTH(DEPTH), .UPCASE(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .AB(AB), .DO(DO), .WE(WE),
        .DI_pia(DI_pia), .pia_hit(pia_hit),
        .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
        .dsp_data(dsp_data), .dsp_valid(dsp_valid), .dsp_ready(dsp_ready),
        .dsp_ovr(dsp_ovr)
    );

    // Reference model state
    logic [6:0] q[$];
    logic [5:0] m_cra, m_crb;
    logic [7:0] m_ddra, m_ddrb, m_di;
    logic       m_hit, m_dv, m_ovr;
    logic [6:0] m_dd, m_last;

    function automatic logic [6:0] upcase(input logic [6:0] c);
        if (c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
        return c;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            q.delete();
            m_cra = '0; m_crb = '0; m_ddra = '0; m_ddrb = '0; m_di = '0;
            m_hit = 1'b0; m_dv = 1'b0; m_ovr = 1'b0; m_dd = '0; m_last = '0;
        end else begin
            bit push, pop, was_dv, inwin;
            int r;
            logic [6:0] popped;
            inwin  = (AB >= BASE) && (int'(AB) <= int'(BASE) + 3);
            r      = int'(AB) - int'(BASE);
            was_dv = m_dv;
            pop    = 1'b0;
            push   = kbd_valid && (q.size() < DEPTH);
            if (en && !WE) begin
                m_hit = inwin;
                if (inwin) begin
                    case (r)
                        0: if (m_cra[2]) begin
                               if (q.size() > 0) begin m_di = {1'b1, q[0]}; pop = 1'b1; end
                               else m_di = {1'b1, m_last};
                           end else m_di = m_ddra;
                        1: m_di = {(q.size() != 0), 1'b0, m_cra};
                        2: m_di = m_crb[2] ? {m_dv, m_dd} : m_ddrb;
                        default: m_di = {2'b00, m_crb};
                    endcase
                end
            end else if (en) begin
                m_hit = 1'b0;
                if (inwin) begin
                    case (r)
                        0: if (!m_cra[2]) m_ddra = DO;
                        1: m_cra = DO[5:0];
                        2: if (!m_crb[2]) m_ddrb = DO;
                           else if (!was_dv) begin m_dd = DO[6:0]; m_dv = 1'b1; end
                           else m_ovr = 1'b1;
                        default: m_crb = DO[5:0];
                    endcase
                end
            end
            if (was_dv && dsp_ready) m_dv = 1'b0;
            if (pop) begin popped = q.pop_front(); m_last = popped; end
            if (push) q.push_back(upcase(kbd_data));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model DI_pia",    32'(DI_pia),    32'(m_di));
            check("model pia_hit",   32'(pia_hit),   32'(m_hit));
            check("model kbd_ready", 32'(kbd_ready), 32'(reset_n && (q.size() < DEPTH)));
            check("model dsp_valid", 32'(dsp_valid), 32'(m_dv));
            check("model dsp_data",  32'(dsp_data),  32'(m_dd));
            check("model dsp_ovr",   32'(dsp_ovr),   32'(m_ovr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus(input logic e, input logic [15:0] a, input logic w, input logic [7:0] d);
        en = e; AB = a; WE = w; DO = d;
        tick();
        en = 1'b0; WE = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string name);
        bus(1'b1, a, 1'b0, 8'h00);
        check(name, 32'(DI_pia), 32'(exp));
        check({name, " hit"}, 32'(pia_hit), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        tick(); tick();
        chk_on  = 1'b1;
        check("reset DI_pia", 32'(DI_pia), 32'h00);
        check("reset pia_hit", 32'(pia_hit), 32'd0);
        check("reset kbd_ready low", 32'(kbd_ready), 32'd0);
        reset_n = 1'b1;
        tick();
        check("kbd_ready after reset", 32'(kbd_ready), 32'd1);
        check("dsp_valid after reset", 32'(dsp_valid), 32'd0);
        rd(16'hD011, 8'h00, "rd KBDCR reset");

        // WozMon init
        bus(1'b1, 16'hD012, 1'b1, 8'h7F);
        bus(1'b1, 16'hD011, 1'b1, 8'hA7);
        bus(1'b1, 16'hD013, 1'b1, 8'hA7);
        check("init no dsp_valid", 32'(dsp_valid), 32'd0);
        rd(16'hD011, 8'h27, "rd CRA init");
        rd(16'hD013, 8'h27, "rd CRB init");

        kbd_valid = 1'b1; kbd_data = 7'h61;
        tick();
        kbd_valid = 1'b0;
        rd(16'hD011, 8'hA7, "rd KBDCR key");
        rd(16'hD010, 8'hC1, "rd KBD upcase");
        rd(16'hD011, 8'h27, "rd KBDCR drained");

        for (int i = 0; i < 4; i++) begin
            kbd_valid = 1'b1; kbd_data = 7'(8'h31 + i);
            tick();
        end
        kbd_valid = 1'b0;
        check("kbd_ready full", 32'(kbd_ready), 32'd0);
        rd(16'hD010, 8'hB1, "pop 1");
        kbd_valid = 1'b1; kbd_data = 7'h35;
        rd(16'hD010, 8'hB2, "push+pop");
        kbd_valid = 1'b0;
        check("kbd_ready depth3", 32'(kbd_ready), 32'd1);
        rd(16'hD010, 8'hB3, "pop 3");
        rd(16'hD010, 8'hB4, "pop 4");
        rd(16'hD010, 8'hB5, "pop 5");
        rd(16'hD010, 8'hB5, "empty last_key");
        rd(16'hD011, 8'h27, "KBDCR empty");

        dsp_ready = 1'b0;
        bus(1'b1, 16'hD012, 1'b1, 8'h8D);
        check("dsp_valid set", 32'(dsp_valid), 32'd1);
        check("dsp_data", 32'(dsp_data), 32'h0D);
        rd(16'hD012, 8'h8D, "rd DSP busy");
        bus(1'b1, 16'hD012, 1'b1, 8'h41);
        check("dsp_ovr", 32'(dsp_ovr), 32'd1);
        check("dsp_data kept", 32'(dsp_data), 32'h0D);
        dsp_ready = 1'b1;
        tick();
        dsp_ready = 1'b0;
        check("dsp_valid clr", 32'(dsp_valid), 32'd0);
        rd(16'hD012, 8'h0D, "rd DSP idle");

        kbd_valid = 1'b1; kbd_data = 7'h61; tick();
        kbd_data = 7'h62; tick();
        kbd_valid = 1'b0;
        bus(1'b1, 16'hD012, 1'b1, 8'h5A);
        reset_n = 1'b0;
        tick();
        check("mid reset DI", 32'(DI_pia), 32'h00);
        check("mid reset hit", 32'(pia_hit), 32'd0);
        check("mid reset dsp_valid", 32'(dsp_valid), 32'd0);
        check("mid reset dsp_data", 32'(dsp_data), 32'h00);
        check("mid reset ovr", 32'(dsp_ovr), 32'd0);
        check("mid reset kbd_ready", 32'(kbd_ready), 32'd0);
        reset_n = 1'b1;
        tick();
        rd(16'hD011, 8'h00, "post reset KBDCR");
        bus(1'b0, 16'hD011, 1'b1, 8'hA7);
        bus(1'b0, 16'h0000, 1'b0, 8'h00);
        check("en0 holds hit", 32'(pia_hit), 32'd1);
        check("en0 holds DI", 32'(DI_pia), 32'h00);
        rd(16'hD011, 8'h00, "en0 write ignored");
        rd(16'hD010, 8'h00, "DDRA reset");

        for (int i = 0; i < 3000; i++) begin
            reset_n   = ($urandom_range(0, 149) != 0);
            en        = ($urandom_range(0, 3) != 0);
            WE        = ($urandom_range(0, 2) == 0);
            AB        = ($urandom_range(0, 4) != 0) ? (BASE + 16'($urandom_range(0, 3)))
                                                    : 16'($urandom);
            DO        = 8'($urandom);
            if ($urandom_range(0, 3) == 0) DO[2] = 1'b1;
            kbd_valid = ($urandom_range(0, 2) == 0);
            kbd_data  = 7'($urandom);
            dsp_ready = ($urandom_range(0, 3) == 0);
            tick();
        end
        en = 1'b0; WE = 1'b0; kbd_valid = 1'b0; reset_n = 1'b1;
        tick();
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
